// File: rtl/bcd_display_pkg.sv
// Shared constants and types for the 3-digit BCD display scanner.
// Segment patterns are logical active-high, bit0=a .. bit6=g.
package bcd_display_pkg;

  localparam int NUM_DIGITS = 3;

  typedef enum logic [1:0] {
    SCAN_D0  = 2'd0,
    SCAN_D1  = 2'd1,
    SCAN_D2  = 2'd2,
    SCAN_BAD = 2'd3
  } scan_idx_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, logical active-high.
// Non-BCD codes show a dash so bad data stays visible.
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_OFF;
    end else begin
      unique case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd3_display_scan.sv
// Time-multiplexed 3-digit common-anode 7-segment driver with
// held BCD digits, leading-zero blanking and a non-BCD error flag.
module bcd3_display_scan
  import bcd_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic       blank,
  input  logic [3:0] BCD0,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  output logic [6:0] seg,
  output logic [2:0] anode,
  output logic [1:0] digit_sel,
  output logic       err
);

  localparam int unsigned PW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_DARK =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_DARK =
    AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [PW-1:0] presc_q, presc_d;
  scan_idx_t     idx_q, idx_d;
  logic [3:0]    h0_q, h1_q, h2_q;
  logic [3:0]    h0_d, h1_d, h2_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic [1:0]    sel_q, sel_d;
  logic          err_q, err_d;

  logic                  tick;
  logic [3:0]            cur;
  logic                  cur_blank;
  logic [6:0]            pat;
  logic [NUM_DIGITS-1:0] hot;

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    h0_d    = load ? BCD0 : h0_q;
    h1_d    = load ? BCD1 : h1_q;
    h2_d    = load ? BCD2 : h2_q;
    err_d   = (h0_q > 4'd9) | (h1_q > 4'd9) | (h2_q > 4'd9);
  end

  // Index 3 is never entered normally; it drives no anode and recovers.
  always_comb begin
    idx_d     = SCAN_D0;
    cur       = 4'h0;
    cur_blank = 1'b1;
    hot       = '0;
    unique case (idx_q)
      SCAN_D0: begin
        idx_d     = tick ? SCAN_D1 : SCAN_D0;
        cur       = h0_q;
        cur_blank = 1'b0;
        hot       = 3'b001;
      end
      SCAN_D1: begin
        idx_d     = tick ? SCAN_D2 : SCAN_D1;
        cur       = h1_q;
        cur_blank = BLANK_LEADING &&
                    (h2_q == 4'd0) && (h1_q == 4'd0);
        hot       = 3'b010;
      end
      SCAN_D2: begin
        idx_d     = tick ? SCAN_D0 : SCAN_D2;
        cur       = h2_q;
        cur_blank = BLANK_LEADING && (h2_q == 4'd0);
        hot       = 3'b100;
      end
      default: begin
        idx_d     = SCAN_D0;
        cur       = 4'h0;
        cur_blank = 1'b1;
        hot       = '0;
      end
    endcase
  end

  bcd_to_7seg u_dec (
    .digit_i (cur),
    .blank_i (cur_blank),
    .seg_o   (pat)
  );

  always_comb begin
    sel_d = idx_q;
    seg_d = SEG_ACTIVE_LOW ? ~pat : pat;
    an_d  = AN_ACTIVE_LOW ? ~hot : hot;
    if (blank) begin
      seg_d = SEG_DARK;
      an_d  = AN_DARK;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      presc_q <= '0;
      idx_q   <= SCAN_D0;
      h0_q    <= 4'h0;
      h1_q    <= 4'h0;
      h2_q    <= 4'h0;
      seg_q   <= SEG_DARK;
      an_q    <= AN_DARK;
      sel_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign seg       = seg_q;
  assign anode     = an_q;
  assign digit_sel = sel_q;
  assign err       = err_q;

endmodule
